// File: rtl/tmr_pkg.sv
// Shared types for the TMR fault manager: FSM state encoding, faulty-replica
// identifiers and the width of the consecutive-mismatch counters.
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_RESYNC = 2'd1,
    ST_FAIL   = 2'd2
  } tmr_state_t;

  localparam logic [1:0] FID_NONE = 2'd0;
  localparam logic [1:0] FID_R1   = 2'd1;
  localparam logic [1:0] FID_R2   = 2'd2;
  localparam logic [1:0] FID_R3   = 2'd3;

  // Consecutive counters saturate at THRESH, which is at most 15.
  localparam int CONS_W = 4;

endpackage

// File: rtl/tmr_voter3.sv
// Combinational 2-of-3 voter: bitwise majority word, per-replica mismatch
// flags against that majority, and a flag for three pairwise-distinct words.
module tmr_voter3 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  output logic [WIDTH-1:0] o_maj,
  output logic [2:0]       o_mism,
  output logic             o_total
);

  assign o_maj   = (i_d1 & i_d2) | (i_d1 & i_d3) | (i_d2 & i_d3);
  assign o_mism  = {(i_d3 != o_maj), (i_d2 != o_maj), (i_d1 != o_maj)};
  assign o_total = (i_d1 != i_d2) && (i_d1 != i_d3) && (i_d2 != i_d3);

endmodule

// File: rtl/tmr_fault_manager.sv
// TMR fault manager: registered majority vote with per-replica consecutive
// mismatch tracking, a NORMAL/RESYNC/FAIL supervisor and optional cumulative
// error counters (built only when TMR_ERR_COUNTERS_EN is defined).
module tmr_fault_manager
  import tmr_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int THRESH = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] data_3,
  input  logic             resync_ack,
  output logic             valid_out,
  output logic [WIDTH-1:0] tmr_out,
  output logic [2:0]       mism,
  output logic [1:0]       faulty_id,
  output logic             resync_req,
  output logic             fail,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] err_cnt_1,
  output logic [CNT_W-1:0] err_cnt_2,
  output logic [CNT_W-1:0] err_cnt_3
);

  localparam logic [CONS_W-1:0] THR = CONS_W'(THRESH);

  logic [WIDTH-1:0]  w_maj;
  logic [2:0]        w_mism;
  logic              w_total;
  logic [CONS_W-1:0] w_cons_nxt [3];
  logic [1:0]        w_hit_id;

  tmr_state_t        r_state;
  logic [WIDTH-1:0]  r_tmr;
  logic [2:0]        r_mism;
  logic              r_valid;
  logic [1:0]        r_fid;
  logic              r_req;
  logic              r_fail;
  logic [CONS_W-1:0] r_cons [3];

  tmr_voter3 #(.WIDTH(WIDTH)) u_voter (
    .i_d1   (data_1),
    .i_d2   (data_2),
    .i_d3   (data_3),
    .o_maj  (w_maj),
    .o_mism (w_mism),
    .o_total(w_total)
  );

  // Next consecutive-mismatch counts: saturating +1 on mismatch, clear on match.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_cons_nxt[i] = r_cons[i];
      if (valid_in) begin
        if (!w_mism[i])        w_cons_nxt[i] = '0;
        else if (r_cons[i] != THR) w_cons_nxt[i] = r_cons[i] + CONS_W'(1);
      end
    end
  end

  // Lowest-index replica whose count reaches THRESH on this sample.
  always_comb begin
    w_hit_id = FID_NONE;
    for (int i = 2; i >= 0; i--) begin
      if (w_cons_nxt[i] == THR) w_hit_id = 2'(i + 1);
    end
  end

  // Supervisor FSM with registered vote outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_NORMAL;
      r_tmr   <= '0;
      r_mism  <= '0;
      r_valid <= 1'b0;
      r_fid   <= FID_NONE;
      r_req   <= 1'b0;
      r_fail  <= 1'b0;
      r_cons  <= '{default: '0};
    end else begin
      r_valid <= 1'b0;
      r_mism  <= '0;
      unique case (r_state)
        ST_NORMAL: begin
          r_cons <= w_cons_nxt;
          if (valid_in && w_total) begin
            r_state <= ST_FAIL;
            r_fail  <= 1'b1;
          end else begin
            if (valid_in) begin
              r_tmr   <= w_maj;
              r_mism  <= w_mism;
              r_valid <= 1'b1;
            end
            if (w_hit_id != FID_NONE) begin
              r_state <= ST_RESYNC;
              r_fid   <= w_hit_id;
              r_req   <= 1'b1;
            end
          end
        end
        ST_RESYNC: begin
          if (valid_in && w_total) begin
            r_state <= ST_FAIL;
            r_fail  <= 1'b1;
            r_req   <= 1'b0;
            r_fid   <= FID_NONE;
          end else begin
            if (valid_in) begin
              r_tmr   <= w_maj;
              r_mism  <= w_mism;
              r_valid <= 1'b1;
            end
            if (resync_ack) begin
              r_state <= ST_NORMAL;
              r_fid   <= FID_NONE;
              r_req   <= 1'b0;
              r_cons  <= '{default: '0};
            end else begin
              r_cons  <= w_cons_nxt;
            end
          end
        end
        ST_FAIL: begin
          r_state <= ST_FAIL;
        end
        default: begin
          r_state <= ST_NORMAL;
        end
      endcase
    end
  end

  assign valid_out  = r_valid;
  assign tmr_out    = r_tmr;
  assign mism       = r_mism;
  assign faulty_id  = r_fid;
  assign resync_req = r_req;
  assign fail       = r_fail;
  assign state_o    = r_state;

`ifdef TMR_ERR_COUNTERS_EN
  logic [CNT_W-1:0] r_err [3];

  // Cumulative saturating mismatch counts; resync never touches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '{default: '0};
    end else if (valid_in && (r_state != ST_FAIL)) begin
      for (int i = 0; i < 3; i++) begin
        if (w_mism[i] && (r_err[i] != {CNT_W{1'b1}})) r_err[i] <= r_err[i] + CNT_W'(1);
      end
    end
  end

  assign err_cnt_1 = r_err[0];
  assign err_cnt_2 = r_err[1];
  assign err_cnt_3 = r_err[2];
`else
  assign err_cnt_1 = '0;
  assign err_cnt_2 = '0;
  assign err_cnt_3 = '0;
`endif

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Bench for tmr_fault_manager: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model of the voting/FSM rules.
module tb_tmr_fault_manager;

  localparam int WIDTH  = 4;
  localparam int THRESH = 3;
  localparam int CNT_W  = 8;
  localparam int ERRMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid_in = 1'b0;
  logic [WIDTH-1:0] data_1 = '0, data_2 = '0, data_3 = '0;
  logic             resync_ack = 1'b0;
  logic             valid_out;
  logic [WIDTH-1:0] tmr_out;
  logic [2:0]       mism;
  logic [1:0]       faulty_id;
  logic             resync_req;
  logic             fail;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] err_cnt_1, err_cnt_2, err_cnt_3;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_state, m_fid, m_req, m_fail, m_valid, m_mism, m_tmr;
  int m_cons [3];
  int m_err  [3];

  tmr_fault_manager #(.WIDTH(WIDTH), .THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .resync_ack(resync_ack), .valid_out(valid_out), .tmr_out(tmr_out),
    .mism(mism), .faulty_id(faulty_id), .resync_req(resync_req), .fail(fail),
    .state_o(state_o), .err_cnt_1(err_cnt_1), .err_cnt_2(err_cnt_2), .err_cnt_3(err_cnt_3)
  );

  always #5 clk = ~clk;

  function automatic int exp_err(input int v);
`ifdef TMR_ERR_COUNTERS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_fid = 0; m_req = 0; m_fail = 0;
    m_valid = 0; m_mism = 0; m_tmr = 0;
    for (int i = 0; i < 3; i++) begin m_cons[i] = 0; m_err[i] = 0; end
  endtask

  // One clock of the specified behaviour, computed from the rules directly.
  task automatic model_clk(input bit r, input bit v, input logic [3:0] a, b, c, input bit ack);
    logic [3:0] maj;
    logic [3:0] w [3];
    bit mm [3];
    bit td;
    int pop, hit;
    if (r) begin model_reset(); return; end
    m_valid = 0; m_mism = 0;
    if (m_state == 2) return;
    w[0] = a; w[1] = b; w[2] = c;
    if (v) begin
      for (int k = 0; k < 4; k++) begin
        pop = 0;
        for (int i = 0; i < 3; i++) if (w[i][k]) pop++;
        maj[k] = (pop >= 2);
      end
      td = (a != b) && (b != c) && (a != c);
      for (int i = 0; i < 3; i++) begin
        mm[i] = (w[i] != maj);
        if (mm[i]) begin
          if (m_err[i] < ERRMAX) m_err[i]++;
          if (m_cons[i] < THRESH) m_cons[i]++;
        end else m_cons[i] = 0;
      end
      if (td) begin
        m_state = 2; m_fail = 1; m_req = 0; m_fid = 0;
        return;
      end
      m_tmr = int'(maj);
      m_mism = (mm[2] ? 4 : 0) + (mm[1] ? 2 : 0) + (mm[0] ? 1 : 0);
      m_valid = 1;
    end
    if (m_state == 1) begin
      if (ack) begin
        m_state = 0; m_fid = 0; m_req = 0;
        for (int i = 0; i < 3; i++) m_cons[i] = 0;
      end
    end else begin
      hit = 0;
      for (int i = 2; i >= 0; i--) if (m_cons[i] == THRESH) hit = i + 1;
      if (hit != 0) begin m_state = 1; m_fid = hit; m_req = 1; end
    end
  endtask

  task automatic cmp_model();
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("tmr_out", 32'(tmr_out), 32'(m_tmr));
    chk("mism", 32'(mism), 32'(m_mism));
    chk("faulty_id", 32'(faulty_id), 32'(m_fid));
    chk("resync_req", 32'(resync_req), 32'(m_req));
    chk("fail", 32'(fail), 32'(m_fail));
    chk("state_o", 32'(state_o), 32'(m_state));
    chk("err_cnt_1", 32'(err_cnt_1), 32'(exp_err(m_err[0])));
    chk("err_cnt_2", 32'(err_cnt_2), 32'(exp_err(m_err[1])));
    chk("err_cnt_3", 32'(err_cnt_3), 32'(exp_err(m_err[2])));
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] a, b, c, input bit ack);
    rst = r; valid_in = v; data_1 = a; data_2 = b; data_3 = c; resync_ack = ack;
    @(posedge clk);
    model_clk(r, v, a, b, c, ack);
    #1;
    cmp_model();
  endtask

  initial begin
    logic [3:0] base, d [3];
    bit r, v, ack;
    model_reset();

    // Reset state
    step(1, 0, 4'h0, 4'h0, 4'h0, 0);
    step(1, 1, 4'hF, 4'h3, 4'h5, 1);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_tmr", 32'(tmr_out), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);

    // Unanimous sample, then an idle cycle holds tmr_out
    step(0, 1, 4'b1101, 4'b1101, 4'b1101, 0);
    chk("s1_tmr", 32'(tmr_out), 32'b1101);
    chk("s1_mism", 32'(mism), 32'b000);
    chk("s1_valid", 32'(valid_out), 32'd1);
    step(0, 0, 4'b0000, 4'b1111, 4'b0101, 0);
    chk("idle_hold_tmr", 32'(tmr_out), 32'b1101);
    chk("idle_valid", 32'(valid_out), 32'd0);

    // Single outvoted replica
    step(0, 1, 4'b1100, 4'b1100, 4'b1001, 0);
    chk("s2_tmr", 32'(tmr_out), 32'b1100);
    chk("s2_mism", 32'(mism), 32'b100);
    chk("s2_err3", 32'(err_cnt_3), 32'(exp_err(1)));
    chk("s2_state", 32'(state_o), 32'd0);

    // Replica 2 persistently wrong, with a gap, then resync
    step(0, 1, 4'b1000, 4'b1110, 4'b1000, 0);
    step(0, 1, 4'b1000, 4'b1110, 4'b1000, 0);
    step(0, 0, 4'b1000, 4'b1110, 4'b1000, 0);
    chk("s3_gap_state", 32'(state_o), 32'd0);
    step(0, 1, 4'b1000, 4'b1110, 4'b1000, 0);
    chk("s3_state", 32'(state_o), 32'd1);
    chk("s3_fid", 32'(faulty_id), 32'd2);
    chk("s3_req", 32'(resync_req), 32'd1);
    step(0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b0101, 4'b0101, 4'b0101, 0);
    chk("s3_vote_in_resync", 32'(tmr_out), 32'b0101);
    step(0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    step(0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    chk("s3_req_held", 32'(resync_req), 32'd1);
    step(0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
    chk("s3_ack_state", 32'(state_o), 32'd0);
    chk("s3_ack_fid", 32'(faulty_id), 32'd0);
    chk("s3_ack_req", 32'(resync_req), 32'd0);
    chk("s3_err2", 32'(err_cnt_2), 32'(exp_err(3)));

    // Replica 1 interrupted mismatch run; stray ack in NORMAL ignored
    step(0, 1, 4'b0001, 4'b0000, 4'b0000, 1);
    step(0, 1, 4'b0001, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b0001, 4'b0000, 4'b0000, 1);
    step(0, 1, 4'b0001, 4'b0000, 4'b0000, 0);
    chk("s4_state", 32'(state_o), 32'd0);
    chk("s4_req", 32'(resync_req), 32'd0);
    chk("s4_err1", 32'(err_cnt_1), 32'(exp_err(4)));

    // Reset mid-RESYNC
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0110, 4'b0110, 4'b0111, 0);
    chk("s6_resync", 32'(state_o), 32'd1);
    chk("s6_fid", 32'(faulty_id), 32'd3);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    chk("s6_state", 32'(state_o), 32'd0);
    chk("s6_req", 32'(resync_req), 32'd0);
    chk("s6_fid0", 32'(faulty_id), 32'd0);
    chk("s6_err3", 32'(err_cnt_3), 32'd0);

    // Total disagreement latches FAIL; only rst leaves it
    step(0, 1, 4'b0011, 4'b0011, 4'b0011, 0);
    step(0, 1, 4'b1000, 4'b1110, 4'b0111, 0);
    chk("s5_fail", 32'(fail), 32'd1);
    chk("s5_state", 32'(state_o), 32'd2);
    chk("s5_valid", 32'(valid_out), 32'd0);
    step(0, 1, 4'b1111, 4'b1111, 4'b1111, 1);
    step(0, 1, 4'b1010, 4'b1010, 4'b1010, 0);
    chk("s5_valid_later", 32'(valid_out), 32'd0);
    chk("s5_tmr_held", 32'(tmr_out), 32'b0011);
    chk("s5_sticky", 32'(state_o), 32'd2);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    chk("s5_rst_state", 32'(state_o), 32'd0);
    chk("s5_rst_fail", 32'(fail), 32'd0);
    chk("s5_rst_tmr", 32'(tmr_out), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      base = 4'($urandom);
      for (int i = 0; i < 3; i++) begin
        d[i] = base;
        if ($urandom_range(0, 5) == 0) d[i] = base ^ (4'b0001 << $urandom_range(0, 3));
      end
      v   = ($urandom_range(0, 4) != 0);
      ack = ($urandom_range(0, 3) == 0);
      r   = (m_state == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
      step(r, v, d[0], d[1], d[2], ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmr_fault_manager.md
TMR_FAULT_MANAGER -- requirements
Module: tmr_fault_manager

Interface
REQ-001 SHALL have parameter WIDTH, default 4: replica data width.
REQ-002 SHALL have parameter THRESH, default 3: consecutive mismatching samples before a replica is declared faulty (range 1..15).
REQ-003 SHALL have parameter CNT_W, default 8: width of the cumulative error counters.
REQ-004 Ports:
- clk  in  1  -- single clock, all state on rising edge.
- rst  in  1  -- reset, synchronous, active-high.
- valid_in  in  1  -- data_1..3 hold a sample.
- data_1, data_2, data_3  in  WIDTH each  -- replica outputs.
- resync_ack  in  1  -- replica resynchronisation complete.
- valid_out  out  1  -- tmr_out and mism hold a new result.
- tmr_out  out  WIDTH  -- registered bitwise 2-of-3 majority.
- mism  out  3  -- bit i-1 set when replica i differs from tmr_out.
- faulty_id  out  2  -- 0 = none, 1..3 = replica under resync.
- resync_req  out  1  -- resynchronisation request.
- fail  out  1  -- uncorrectable disagreement, sticky.
- state_o  out  2  -- current FSM state.
- err_cnt_1, err_cnt_2, err_cnt_3  out  CNT_W each  -- cumulative mismatch counts.

Function
REQ-005 Latency SHALL be 1 cycle: when valid_in=1 in cycle N, tmr_out, mism and valid_out=1 SHALL appear in cycle N+1.
REQ-006 When valid_in=0, tmr_out SHALL hold its value, and mism and valid_out SHALL be 0.
REQ-007 A replica's mismatch SHALL mean its word differs from the majority in any bit.
REQ-008 A total disagreement SHALL mean a valid sample where data_1, data_2 and data_3 are pairwise unequal.
REQ-009 Each replica SHALL have a consecutive-mismatch counter, updated only on valid samples:
- +1 on mismatch, saturating at THRESH.
- cleared on match.
- held on invalid cycles.
REQ-010 FSM states SHALL be NORMAL=0, RESYNC=1, FAIL=2.
REQ-011 In NORMAL:
- total disagreement SHALL go to FAIL.
- otherwise, a consecutive counter reaching THRESH SHALL go to RESYNC with faulty_id set to that replica; when several reach THRESH together, the lowest index wins.
- FAIL SHALL take priority over RESYNC.
REQ-012 In RESYNC:
- resync_req=1 SHALL be held until resync_ack is sampled 1.
- on ack, the next state SHALL be NORMAL, faulty_id=0, and all consecutive counters cleared.
- voting SHALL continue.
- total disagreement SHALL go to FAIL.
REQ-013 resync_ack outside RESYNC SHALL be ignored.
REQ-014 In FAIL, fail=1 and valid_out=0; tmr_out SHALL hold; only rst exits FAIL.
REQ-015 err_cnt_i SHALL increment on each valid mismatch of replica i, SHALL saturate at 2^CNT_W-1, and SHALL be unaffected by resync.

Reset
REQ-016 With rst=1 at a clock edge:
- state SHALL be NORMAL.
- tmr_out, mism, valid_out, faulty_id, resync_req, fail and all counters SHALL be 0.
- this applies in any state, including mid-RESYNC.

Configuration
REQ-017 With TMR_ERR_COUNTERS_EN defined, the err_cnt_1..3 logic SHALL be built per REQ-015.
REQ-018 Without TMR_ERR_COUNTERS_EN, err_cnt_1..3 SHALL be constant 0 and no counter flops SHALL be built; all other behaviour SHALL be unchanged.

Structure
REQ-019 Package tmr_pkg SHALL hold:
- the state enum (NORMAL/RESYNC/FAIL).
- the faulty_id encoding constants (NONE=0, R1..R3).
REQ-020 Sub-module tmr_voter3 SHALL be combinational, producing the majority word, the 3 mismatch flags and the total-disagreement flag.

Verification
REQ-021 The bench SHALL cover at least the following:
- All replicas 1101, valid_in=1 -> next cycle tmr_out=1101, mism=000, valid_out=1.
- Inputs 1100/1100/1001 -> tmr_out=1100, mism=100, err_cnt_3=1, state NORMAL.
- Replica 2 = 1110 vs 1000/1000 for 3 valid samples, including one invalid cycle in between -> after the 3rd: state RESYNC, faulty_id=2, resync_req=1; resync_ack pulsed 5 cycles later -> next cycle NORMAL, faulty_id=0, resync_req=0, err_cnt_2=3.
- Replica 1 mismatches twice, matches once, mismatches twice -> no RESYNC, err_cnt_1=4.
- Inputs 1000/1110/0111 -> fail=1, state FAIL, valid_out=0 on later valid samples, tmr_out held; rst -> all zero, NORMAL.
- rst asserted mid-RESYNC -> next cycle NORMAL, resync_req=0, faulty_id=0; build without TMR_ERR_COUNTERS_EN -> err_cnt_* stay 0 across all scenarios.
